// File: rtl/ifu_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The FSM state encoding, the NOP fill word and the fetch-group width live here.
package ifu_fetch_resp_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_DATA   = 3'd2,
      S_VALID  = 3'd3,
      S_CANCEL = 3'd4
   } state_t;

   localparam logic [31:0] INST_NOP    = 32'h0000_0000;
   localparam int          FETCH_WIDTH = 2;

   // The bus always reads the 8-byte-aligned doubleword that holds pc.
   function automatic logic [31:0] align_addr(input logic [31:0] a);
      return {a[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/ifu_fetch_resp_if.sv
// SRAM-like instruction bus between the fetch responder (master) and memory (slave).
// Handshake: inst_req/inst_addr are held until a cycle with inst_addr_ok; exactly one
// inst_data_ok with inst_rdata follows later, and only one read is outstanding at a time.
interface ifu_fetch_resp_if;
   import ifu_fetch_resp_pkg::*;

   logic                        inst_req;
   logic [31:0]                 inst_addr;
   logic                        inst_addr_ok;
   logic                        inst_data_ok;
   logic [FETCH_WIDTH*32-1:0]   inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );

endinterface

// File: rtl/ifu_fetch_resp_fetch_align.sv
// Picks the instruction word(s) of a returned doubleword that belong to the fetch group.
// An odd-slot PC only has one valid instruction left in its doubleword.
module ifu_fetch_resp_fetch_align
   import ifu_fetch_resp_pkg::*;
(
   input  logic [FETCH_WIDTH*32-1:0] rdata,
   input  logic                      odd_slot,
   output logic [31:0]               word1,
   output logic [31:0]               word2,
   output logic                      pair_valid
);

   always_comb begin
      word1      = rdata[31:0];
      word2      = rdata[63:32];
      pair_valid = 1'b1;
      if (odd_slot) begin
         word1      = rdata[63:32];
         word2      = INST_NOP;
         pair_valid = 1'b0;
      end
   end

endmodule

// File: rtl/ifu_fetch_resp.sv
// Instruction-fetch responder: one 64-bit read per fetch group, delivers one or two
// instructions, holds them under stall and discards reads made stale by a redirect.
module ifu_fetch_resp
   import ifu_fetch_resp_pkg::*;
#(
   parameter state_t RESET_STATE = S_IDLE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pc,
   input  logic                  flush,
   input  logic                  stall,
   output logic [31:0]           inst_rdata_1,
   output logic [31:0]           inst_rdata_2,
   output logic                  inst_rdata_1_ok,
   output logic                  inst_rdata_2_ok,
   output logic [31:0]           inst_pc,
   output logic                  fetch_adel,
   ifu_fetch_resp_if.master      bus,
   output state_t                dbg_state
);

   state_t      state_q, state_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] rd1_q, rd1_d;
   logic [31:0] rd2_q, rd2_d;
   logic        pair_q, pair_d;
   logic        adel_q, adel_d;

   logic [31:0] al_word1, al_word2;
   logic        al_pair;
   logic        pc_misaligned;

   assign pc_misaligned = |pc[1:0];
   assign bus.inst_addr = align_addr(pc);

   // inst_pc_q is already latched when data returns, so it selects the slot.
   ifu_fetch_resp_fetch_align u_align (
      .rdata      (bus.inst_rdata),
      .odd_slot   (inst_pc_q[2]),
      .word1      (al_word1),
      .word2      (al_word2),
      .pair_valid (al_pair)
   );

   always_comb begin
      state_d         = state_q;
      inst_pc_d       = inst_pc_q;
      rd1_d           = rd1_q;
      rd2_d           = rd2_q;
      pair_d          = pair_q;
      adel_d          = adel_q;
      bus.inst_req    = 1'b0;
      inst_rdata_1_ok = 1'b0;
      inst_rdata_2_ok = 1'b0;

      unique case (state_q)
         S_IDLE: state_d = S_ADDR;

         S_ADDR: begin
            if (pc_misaligned) begin
               // A redirect replaces the faulting pc, so no exception is reported for it.
               if (!flush) begin
                  inst_pc_d = pc;
                  adel_d    = 1'b1;
                  rd1_d     = INST_NOP;
                  rd2_d     = INST_NOP;
                  pair_d    = 1'b0;
                  state_d   = S_VALID;
               end
            end else begin
               bus.inst_req = 1'b1;
               if (bus.inst_addr_ok) begin
                  if (flush) begin
                     state_d = S_CANCEL;
                  end else begin
                     inst_pc_d = pc;
                     adel_d    = 1'b0;
                     state_d   = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            if (bus.inst_data_ok) begin
               if (flush) begin
                  state_d = S_ADDR;
               end else begin
                  rd1_d   = al_word1;
                  rd2_d   = al_word2;
                  pair_d  = al_pair;
                  state_d = S_VALID;
               end
            end else if (flush) begin
               state_d = S_CANCEL;
            end
         end

         S_VALID: begin
            inst_rdata_1_ok = ~stall & ~flush;
            inst_rdata_2_ok = ~stall & ~flush & pair_q;
            if (~stall | flush) state_d = S_ADDR;
         end

         // The read is still in flight on the bus; wait it out before issuing another.
         S_CANCEL: begin
            if (bus.inst_data_ok) state_d = S_ADDR;
         end

         default: state_d = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RESET_STATE;
         inst_pc_q <= 32'h0;
         rd1_q     <= INST_NOP;
         rd2_q     <= INST_NOP;
         pair_q    <= 1'b0;
         adel_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         inst_pc_q <= inst_pc_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         pair_q    <= pair_d;
         adel_q    <= adel_d;
      end
   end

   assign inst_rdata_1 = rd1_q;
   assign inst_rdata_2 = rd2_q;
   assign inst_pc      = inst_pc_q;
   assign fetch_adel   = adel_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ifu_fetch_resp.sv
// Bench for ifu_fetch_resp: acts as PC register and instruction memory, and checks every
// delivered fetch group against an expected queue filled as reads are accepted.
module tb_ifu_fetch_resp;
   import ifu_fetch_resp_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] pc, pc_next, flush_target;
   logic        flush, stall;
   logic [31:0] inst_rdata_1, inst_rdata_2, inst_pc;
   logic        inst_rdata_1_ok, inst_rdata_2_ok, fetch_adel;
   state_t      dbg_state;

   ifu_fetch_resp_if bus ();

   ifu_fetch_resp dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .flush           (flush),
      .stall           (stall),
      .inst_rdata_1    (inst_rdata_1),
      .inst_rdata_2    (inst_rdata_2),
      .inst_rdata_1_ok (inst_rdata_1_ok),
      .inst_rdata_2_ok (inst_rdata_2_ok),
      .inst_pc         (inst_pc),
      .fetch_adel      (fetch_adel),
      .bus             (bus),
      .dbg_state       (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   // Entry layout: {pc[31:0], word1[31:0], word2[31:0], pair, adel}
   logic [97:0] exp_q[$];
   logic [97:0] e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_no   = 0;
   int          hs_cyc   = 0;
   int          last_ok_cyc = -10;

   // memory model
   int          addr_wait, data_lat, req_cnt, wait_cnt;
   logic        pend, stray, fixed_en, saw_ok, lat_chk;
   logic [63:0] fixed_data, pend_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   function automatic logic [63:0] data_for(input logic [31:0] a);
      if (fixed_en) return fixed_data;
      return {a ^ 32'hA5A5_0004, a ^ 32'h5A5A_0000};
   endfunction

   function automatic logic [97:0] make_exp(input logic [31:0] a, input logic [63:0] d);
      if (a[2]) return {a, d[63:32], 32'h0, 1'b0, 1'b0};
      return {a, d[31:0], d[63:32], 1'b1, 1'b0};
   endfunction

   function automatic logic [97:0] make_adel(input logic [31:0] a);
      return {a, 32'h0, 32'h0, 1'b0, 1'b1};
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic cyc(input logic r, input logic fl, input logic st);
      logic pend_start;
      @(negedge clk);
      cyc_no++;
      rst = r; pc = pc_next; flush = fl; stall = st;
      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = {$urandom, $urandom};
      saw_ok = 1'b0;
      #1;
      if (!r) begin
         if (stray) begin
            bus.inst_data_ok = 1'b1;
            stray = 1'b0;
         end
         pend_start = pend;
         if (pend_start) begin
            check("one_outstanding", 64'(bus.inst_req), 64'd0);
            if (wait_cnt == 0) begin
               bus.inst_data_ok = 1'b1;
               bus.inst_rdata   = pend_data;
               pend = 1'b0;
            end else begin
               wait_cnt--;
            end
         end else if (bus.inst_req) begin
            check("inst_addr", 64'(bus.inst_addr), 64'({pc[31:3], 3'b000}));
            if (req_cnt >= addr_wait) begin
               bus.inst_addr_ok = 1'b1;
               pend      = 1'b1;
               wait_cnt  = data_lat - 1;
               pend_data = data_for({pc[31:3], 3'b000});
               req_cnt   = 0;
               hs_cyc    = cyc_no;
               if (!fl) exp_q.push_back(make_exp(pc, pend_data));
            end else begin
               req_cnt++;
            end
         end
         if (last_ok_cyc == cyc_no - 1 && pc[1:0] == 2'b00)
            check("req_after_ok", 64'(bus.inst_req), 64'd1);
         if (pc[1:0] != 2'b00) check("no_req_misaligned", 64'(bus.inst_req), 64'd0);
      end
      #1;
      if (r) begin
         pend = 1'b0;
         req_cnt = 0;
         exp_q.delete();
      end else begin
         if (inst_rdata_2_ok) check("ok2_implies_ok1", 64'(inst_rdata_1_ok), 64'd1);
         if (fl) check("ok_during_flush", 64'(inst_rdata_1_ok), 64'd0);
         if (st) check("ok_during_stall", 64'(inst_rdata_1_ok), 64'd0);
         if (inst_rdata_1_ok) begin
            saw_ok = 1'b1;
            last_ok_cyc = cyc_no;
            if (exp_q.size() == 0) begin
               check("unexpected_ok", 64'(inst_rdata_1_ok), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("inst_pc", 64'(inst_pc), 64'(e[97:66]));
               check("rdata_1", 64'(inst_rdata_1), 64'(e[65:34]));
               if (!e[0]) check("rdata_2", 64'(inst_rdata_2), 64'(e[33:2]));
               check("ok_2", 64'(inst_rdata_2_ok), 64'(e[1]));
               check("fetch_adel", 64'(fetch_adel), 64'(e[0]));
               if (lat_chk) check("ok_latency", 64'(cyc_no - hs_cyc), 64'd2);
            end
            pc_next = pc + (inst_rdata_2_ok ? 32'd8 : 32'd4);
            if (pc_next[1:0] != 2'b00) exp_q.push_back(make_adel(pc_next));
         end
         if (fl) begin
            exp_q.delete();
            pc_next = flush_target;
            if (pc_next[1:0] != 2'b00) exp_q.push_back(make_adel(pc_next));
         end
      end
   endtask

   task automatic wait_ok(input int budget);
      int n;
      n = 0;
      do begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end while (!saw_ok && n < budget);
      if (!saw_ok) check("wait_ok_timeout", 64'd0, 64'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; pc = 32'hBFC0_0000; pc_next = 32'hBFC0_0000; flush = 1'b0; stall = 1'b0;
      flush_target = 32'h0;
      bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
      addr_wait = 0; data_lat = 1; req_cnt = 0; wait_cnt = 0;
      pend = 1'b0; stray = 1'b0; saw_ok = 1'b0; lat_chk = 1'b0;
      fixed_en = 1'b1; fixed_data = 64'h2222_2222_1111_1111;

      // reset values
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      check("rst_inst_req", 64'(bus.inst_req), 64'd0);
      check("rst_ok_1", 64'(inst_rdata_1_ok), 64'd0);
      check("rst_ok_2", 64'(inst_rdata_2_ok), 64'd0);
      check("rst_adel", 64'(fetch_adel), 64'd0);
      check("rst_rdata_1", 64'(inst_rdata_1), 64'd0);
      check("rst_rdata_2", 64'(inst_rdata_2), 64'd0);
      check("rst_inst_pc", 64'(inst_pc), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));

      // aligned pair, zero-wait bus
      lat_chk = 1'b1;
      wait_ok(10);
      lat_chk = 1'b0;

      // flush coincident with addr_ok: cancel until the stale data returns
      flush_target = 32'h8000_2000; data_lat = 3;
      cyc(1'b0, 1'b1, 1'b0);
      fixed_en = 1'b0; data_lat = 1;
      cyc(1'b0, 1'b0, 1'b0);
      check("cancel_state", 64'(dbg_state), 64'(S_CANCEL));
      wait_ok(10);

      // flush without addr_ok stays in ADDR; odd slot delivery
      addr_wait = 2; flush_target = 32'hBFC0_0004; fixed_en = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("flush_stays_addr", 64'(dbg_state), 64'(S_ADDR));
      wait_ok(10);
      addr_wait = 0; fixed_en = 1'b0;

      // stall hold for 3 VALID cycles
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         if (i >= 2) begin
            if (exp_q.size() == 0) begin
               check("stall_exp_present", 64'd0, 64'd1);
            end else begin
               e = exp_q[0];
               check("stall_hold_pc", 64'(inst_pc), 64'(e[97:66]));
               check("stall_hold_rd1", 64'(inst_rdata_1), 64'(e[65:34]));
               check("stall_hold_rd2", 64'(inst_rdata_2), 64'(e[33:2]));
            end
         end
      end
      cyc(1'b0, 1'b0, 1'b0);
      check("stall_release_ok", 64'(saw_ok), 64'd1);

      // flush in DATA, stale 0xDEADBEEF returns while cancelled
      fixed_en = 1'b1; fixed_data = 64'hDEAD_BEEF_DEAD_BEEF; data_lat = 3;
      cyc(1'b0, 1'b0, 1'b0);
      check("single_ok_pulse", 64'(saw_ok), 64'd0);
      flush_target = 32'h8000_1000;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      fixed_en = 1'b0; data_lat = 1;
      cyc(1'b0, 1'b0, 1'b0);
      check("redirect_req", 64'(bus.inst_req), 64'd1);
      check("redirect_addr", 64'(bus.inst_addr), 64'h8000_1000);
      wait_ok(10);

      // flush coincident with data_ok drops the data
      cyc(1'b0, 1'b0, 1'b0);
      flush_target = 32'h8000_3000;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("flush_data_req", 64'(bus.inst_req), 64'd1);
      check("flush_data_addr", 64'(bus.inst_addr), 64'h8000_3000);
      wait_ok(10);

      // misaligned pc reaches the core as an address-error slot
      flush_target = 32'hBFC0_0002;
      cyc(1'b0, 1'b1, 1'b0);
      wait_ok(10);

      // reset mid-transaction; stray data_ok of the abandoned read is ignored
      pc_next = 32'hBFC0_0100;
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      stray = 1'b1; data_lat = 3;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      stray = 1'b1; data_lat = 1;
      cyc(1'b0, 1'b0, 1'b0);
      check("rst_mid_idle", 64'(dbg_state), 64'(S_IDLE));
      wait_ok(10);

      check("exp_q_drained", 64'(exp_q.size()), 64'd0);

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_no);
      $fatal(1, "watchdog expired");
   end

endmodule
